// File: rtl/lbp_pkg.sv
// Shared types and constants for the LBP min/max tracker.
// The optional error checker in the tracker is enabled by defining LBP_TRACKER_ERRCHK_EN.
package lbp_pkg;

  localparam int DATA_W      = 16;
  localparam int LAT_W       = 4;   // wide enough for a comparator latency of 1..15
  localparam int WIN_LEN_DEF = 16;
  localparam int CMP_LAT_DEF = 2;
  localparam int CNT_W_DEF   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Window result as seen by the consumer; the count is carried separately
  // because its width follows the CNT_W parameter of each instance.
  typedef struct packed {
    logic [DATA_W-1:0] max_val;
    logic [DATA_W-1:0] min_val;
  } window_t;

endpackage

// File: rtl/lbp_lat_timer.sv
// Loadable down-counter used to time the comparator flag latency.
// It counts down to zero and parks there; zero marks the flag-sampling cycle.
module lbp_lat_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_reg;

  // Load on request, otherwise decrement until zero is reached.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - W'(1);
    end
  end

  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/lbp_minmax_tracker.sv
// Initiator side of the pivot/min/max comparator interface.
// Tracks the running maximum/minimum of a window of WIN_LEN samples using an
// external comparator with CMP_LAT cycles of flag latency, then strobes the
// window result. Optional error checking: define LBP_TRACKER_ERRCHK_EN.
module lbp_minmax_tracker
  import lbp_pkg::*;
#(
  parameter int WIN_LEN = WIN_LEN_DEF,
  parameter int CMP_LAT = CMP_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              win_clr,
  output logic [DATA_W-1:0] Pivot_x,
  output logic [DATA_W-1:0] LBP1_max,
  output logic [DATA_W-1:0] LBP2_min,
  output logic              minmax_on,
  input  logic              LBP1_max_out,
  input  logic              LBP2_min_out,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_max,
  output logic [DATA_W-1:0] res_min,
  output logic [CNT_W-1:0]  res_count
`ifdef LBP_TRACKER_ERRCHK_EN
  ,
  output logic              err_sticky,
  output logic [7:0]        err_cnt
`endif
);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [DATA_W-1:0] pivot_reg, pivot_next;
  logic [DATA_W-1:0] max_reg, max_next;
  logic [DATA_W-1:0] min_reg, min_next;
  logic              on_reg, on_next;
  logic              ready_reg, ready_next;
  logic              res_valid_reg, res_valid_next;
  window_t           res_reg, res_next;
  logic [CNT_W-1:0]  res_count_reg, res_count_next;
  logic              lat_load;
  logic              lat_zero;
  logic              accept;

  // s_ready is registered so that it stays low throughout reset and only
  // rises on the first clock edge after release.
  assign accept = ready_reg & s_valid;

  lbp_lat_timer #(
    .W(LAT_W)
  ) u_lat (
    .clk     (clk),
    .reset   (reset),
    .load    (lat_load),
    .load_val(LAT_W'(CMP_LAT - 1)),
    .zero    (lat_zero)
  );

  // Next-state, datapath and result decode; win_clr overrides everything.
  always_comb begin
    state_next     = state_reg;
    count_next     = count_reg;
    pivot_next     = pivot_reg;
    max_next       = max_reg;
    min_next       = min_reg;
    on_next        = on_reg;
    lat_load       = 1'b0;
    res_next       = res_reg;
    res_count_next = res_count_reg;

    if (win_clr) begin
      state_next = IDLE;
      count_next = '0;
      on_next    = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (count_reg == '0) begin
              // First sample seeds both extremes without a comparison.
              max_next   = s_data;
              min_next   = s_data;
              count_next = CNT_W'(1);
              if (WIN_LEN == 1) state_next = DONE;
            end else begin
              pivot_next = s_data;
              on_next    = 1'b1;
              lat_load   = 1'b1;
              state_next = WAIT;
            end
          end
        end
        WAIT: begin
          if (lat_zero) begin
            if (LBP1_max_out) max_next = pivot_reg;
            if (LBP2_min_out) min_next = pivot_reg;
            count_next = count_reg + CNT_W'(1);
            on_next    = 1'b0;
            state_next = (count_reg + CNT_W'(1) == CNT_W'(WIN_LEN)) ? DONE : IDLE;
          end
        end
        DONE: begin
          count_next = '0;
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end

    ready_next     = (state_next == IDLE);
    res_valid_next = (state_next == DONE);
    if (state_next == DONE) begin
      res_next.max_val = max_next;
      res_next.min_val = min_next;
      res_count_next   = count_next;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      pivot_reg     <= '0;
      max_reg       <= '0;
      min_reg       <= '0;
      on_reg        <= 1'b0;
      ready_reg     <= 1'b0;
      res_valid_reg <= 1'b0;
      res_reg       <= '0;
      res_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      pivot_reg     <= pivot_next;
      max_reg       <= max_next;
      min_reg       <= min_next;
      on_reg        <= on_next;
      ready_reg     <= ready_next;
      res_valid_reg <= res_valid_next;
      res_reg       <= res_next;
      res_count_reg <= res_count_next;
    end
  end

  assign s_ready   = ready_reg;
  assign Pivot_x   = pivot_reg;
  assign LBP1_max  = max_reg;
  assign LBP2_min  = min_reg;
  assign minmax_on = on_reg;
  assign res_valid = res_valid_reg;
  assign res_max   = res_reg.max_val;
  assign res_min   = res_reg.min_val;
  assign res_count = res_count_reg;

`ifdef LBP_TRACKER_ERRCHK_EN
  logic       err_event;
  logic       err_sticky_reg;
  logic [7:0] err_cnt_reg;

  // Both flags at once is impossible for a healthy comparator, and an
  // inverted max/min pair means the registers have been corrupted.
  assign err_event = (state_reg == WAIT) &&
                     ((lat_zero && LBP1_max_out && LBP2_min_out) || (max_reg < min_reg));

  // Sticky error flag plus a saturating event counter; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_sticky_reg <= 1'b0;
      err_cnt_reg    <= '0;
    end else if (err_event) begin
      err_sticky_reg <= 1'b1;
      if (err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign err_sticky = err_sticky_reg;
  assign err_cnt    = err_cnt_reg;
`endif

endmodule

// File: tb/tb_lbp_minmax_tracker.sv
// Self-checking bench for lbp_minmax_tracker: directed window sequences,
// a table of vectors, randomized windows against a sample-list model, and
// (with LBP_TRACKER_ERRCHK_EN) the error counter.
module tb_lbp_minmax_tracker;
  import lbp_pkg::*;

  localparam int WL = 4;
  localparam int CL = 2;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        win_clr;
  logic [15:0] pivot_x, lbp1_max, lbp2_min;
  logic        minmax_on;
  logic        gt_flag, lt_flag;
  logic        res_valid;
  logic [15:0] res_max, res_min;
  logic [CW-1:0] res_count;

  logic        s1_valid;
  logic [15:0] s1_data;
  logic        s1_ready;
  logic [15:0] pivot1, max1, min1;
  logic        on1;
  logic        res1_valid;
  logic [15:0] res1_max, res1_min;
  logic [CW-1:0] res1_count;

`ifdef LBP_TRACKER_ERRCHK_EN
  logic        err_sticky, err1_sticky;
  logic [7:0]  err_cnt, err1_cnt;
`endif

  lbp_minmax_tracker #(.WIN_LEN(WL), .CMP_LAT(CL), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .win_clr(win_clr), .Pivot_x(pivot_x), .LBP1_max(lbp1_max), .LBP2_min(lbp2_min),
    .minmax_on(minmax_on), .LBP1_max_out(gt_flag), .LBP2_min_out(lt_flag),
    .res_valid(res_valid), .res_max(res_max), .res_min(res_min), .res_count(res_count)
`ifdef LBP_TRACKER_ERRCHK_EN
    , .err_sticky(err_sticky), .err_cnt(err_cnt)
`endif
  );

  // Single-sample windows; its flag inputs are held high and must never matter.
  lbp_minmax_tracker #(.WIN_LEN(1), .CMP_LAT(3), .CNT_W(CW)) dut1 (
    .clk(clk), .reset(reset), .s_valid(s1_valid), .s_data(s1_data), .s_ready(s1_ready),
    .win_clr(1'b0), .Pivot_x(pivot1), .LBP1_max(max1), .LBP2_min(min1),
    .minmax_on(on1), .LBP1_max_out(1'b1), .LBP2_min_out(1'b1),
    .res_valid(res1_valid), .res_max(res1_max), .res_min(res1_min), .res_count(res1_count)
`ifdef LBP_TRACKER_ERRCHK_EN
    , .err_sticky(err1_sticky), .err_cnt(err1_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] mx;
    logic [15:0] mn;
    int          cnt;
  } res_t;

  typedef struct {
    logic [15:0] s [WL];
    logic [15:0] mx;
    logic [15:0] mn;
  } vec_t;

  logic [15:0] win_q[$];
  res_t        exp_q[$];
  int          age = 0;
  bit          force_both = 1'b0;
  bit          on1_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: the window is just the list of accepted samples.
  function automatic void note_accept(input logic [15:0] d);
    res_t e;
    win_q.push_back(d);
    if (win_q.size() == WL) begin
      e.mx = win_q[0];
      e.mn = win_q[0];
      foreach (win_q[i]) begin
        if (win_q[i] > e.mx) e.mx = win_q[i];
        if (win_q[i] < e.mn) e.mn = win_q[i];
      end
      e.cnt = WL;
      exp_q.push_back(e);
      win_q.delete();
    end
  endfunction

  // Cycles since the current comparison was launched.
  always @(posedge clk) age <= minmax_on ? age + 1 : 0;

  // Comparator emulation: correct flags only in the cycle before the sampling
  // edge, random noise otherwise, both forced high on request.
  initial begin
    gt_flag = 1'b0;
    lt_flag = 1'b0;
    forever begin
      @(negedge clk);
      if (force_both) begin
        gt_flag = 1'b1;
        lt_flag = 1'b1;
      end else if (minmax_on && age == CL - 1) begin
        gt_flag = (pivot_x > lbp1_max);
        lt_flag = (pivot_x < lbp2_min);
      end else begin
        gt_flag = 1'($urandom_range(0, 1));
        lt_flag = 1'($urandom_range(0, 1));
      end
    end
  end

  // Result scoreboard: every strobe must match the next modelled window.
  always @(negedge clk) begin
    if (reset && res_valid) begin
      $display("result max=%0h min=%0h count=%0d", res_max, res_min, res_count);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: res_valid=1 required no strobe");
      end else begin
        res_t r;
        r = exp_q.pop_front();
        check("sb_max", 32'(res_max), 32'(r.mx));
        check("sb_min", 32'(res_min), 32'(r.mn));
        check("sb_count", 32'(res_count), 32'(r.cnt));
      end
    end
    if (on1) on1_seen = 1'b1;
  end

  task automatic send(input logic [15:0] d);
    int n;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: s_ready=0 required 1 within 50 cycles");
      s_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      note_accept(d);
    end
  endtask

  task automatic clear_window();
    @(negedge clk);
    win_clr = 1'b1;
    @(posedge clk);
    #1;
    win_clr = 1'b0;
    win_q.delete();
  endtask

  task automatic wait_strobe(input string name, input logic [15:0] mx, input logic [15:0] mn);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!res_valid && n < 20);
    if (!res_valid) begin
      total++;
      bad++;
      $display("FAIL %s_strobe: res_valid=0 required 1 within 20 cycles", name);
    end else begin
      check({name, "_max"}, 32'(res_max), 32'(mx));
      check({name, "_min"}, 32'(res_min), 32'(mn));
      check({name, "_count"}, 32'(res_count), 32'(WL));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at 100000 required finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs [4];
  logic [15:0] d;
  int k;

  initial begin
    vecs[0].s = '{16'd7, 16'd7, 16'd7, 16'd7};             vecs[0].mx = 16'd7;     vecs[0].mn = 16'd7;
    vecs[1].s = '{16'h0000, 16'hFFFF, 16'h8000, 16'h0001}; vecs[1].mx = 16'hFFFF;  vecs[1].mn = 16'h0000;
    vecs[2].s = '{16'hFFFF, 16'hFFFE, 16'hFFFF, 16'hFFFE}; vecs[2].mx = 16'hFFFF;  vecs[2].mn = 16'hFFFE;
    vecs[3].s = '{16'd5, 16'd4, 16'd3, 16'd2};             vecs[3].mx = 16'd5;     vecs[3].mn = 16'd2;

    reset = 1'b0; s_valid = 1'b0; s_data = '0; win_clr = 1'b0;
    s1_valid = 1'b0; s1_data = '0;
    #1;
    check("rst_ready", 32'(s_ready), 0);
    check("rst_pivot", 32'(pivot_x), 0);
    check("rst_max", 32'(lbp1_max), 0);
    check("rst_min", 32'(lbp2_min), 0);
    check("rst_on", 32'(minmax_on), 0);
    check("rst_res", {15'd0, res_valid, res_max}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Window 10,30,5,20 with handshake and strobe timing.
    send(16'd10);
    send(16'd30);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check($sformatf("gap30_ready%0d", i), 32'(s_ready), 32'(i == 3));
      check($sformatf("gap30_on%0d", i), 32'(minmax_on), 32'(i < 3));
    end
    check("pivot30", 32'(pivot_x), 32'd30);
    check("max30", 32'(lbp1_max), 32'd30);
    send(16'd5);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check($sformatf("gap5_ready%0d", i), 32'(s_ready), 32'(i == 3));
    end
    check("min5", 32'(lbp2_min), 32'd5);
    send(16'd20);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("last_strobe%0d", i), 32'(res_valid), 32'(i == 3));
      check($sformatf("last_ready%0d", i), 32'(s_ready), 32'(i == 4));
      if (i == 3) begin
        check("w1_max", 32'(res_max), 32'd30);
        check("w1_min", 32'(res_min), 32'd5);
        check("w1_count", 32'(res_count), 32'd4);
      end
    end
    check("w1_hold_max", 32'(res_max), 32'd30);

    // Table of complete windows.
    for (int v = 0; v < 4; v++) begin
      for (int j = 0; j < WL; j++) send(vecs[v].s[j]);
      wait_strobe($sformatf("vec%0d", v), vecs[v].mx, vecs[v].mn);
    end

    // Single-sample window instance.
    @(negedge clk);
    s1_valid = 1'b1;
    s1_data  = 16'hBEEF;
    check("w1len_ready", 32'(s1_ready), 1);
    @(posedge clk);
    #1;
    s1_valid = 1'b0;
    @(negedge clk);
    check("w1len_strobe", 32'(res1_valid), 1);
    check("w1len_max", 32'(res1_max), 32'hBEEF);
    check("w1len_min", 32'(res1_min), 32'hBEEF);
    check("w1len_count", 32'(res1_count), 1);
    @(negedge clk);
    check("w1len_strobe_off", 32'(res1_valid), 0);

    // Abort in WAIT, then a clear that collides with a transfer.
    send(16'd50);
    send(16'd60);
    clear_window();
    @(negedge clk);
    check("clr_ready", 32'(s_ready), 1);
    s_valid = 1'b1;
    s_data  = 16'd99;
    win_clr = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    win_clr = 1'b0;
    @(negedge clk);
    check("clr_drop_ready", 32'(s_ready), 1);
    for (int j = 1; j <= 4; j++) send(16'(j));
    wait_strobe("after_clr", 16'd4, 16'd1);

    // Asynchronous reset in the middle of WAIT.
    send(16'd100);
    send(16'd200);
    #3;
    reset = 1'b0;
    #1;
    win_q.delete();
    exp_q.delete();
    check("arst_ready", 32'(s_ready), 0);
    check("arst_pivot", 32'(pivot_x), 0);
    check("arst_max", 32'(lbp1_max), 0);
    check("arst_min", 32'(lbp2_min), 0);
    check("arst_on", 32'(minmax_on), 0);
    check("arst_res_max", 32'(res_max), 0);
    check("arst_res_min", 32'(res_min), 0);
    check("arst_res_count", 32'(res_count), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    send(16'h1234);
    @(negedge clk);
    check("reinit_max", 32'(lbp1_max), 32'h1234);
    check("reinit_min", 32'(lbp2_min), 32'h1234);
    for (int j = 0; j < 3; j++) send(16'h1000 + 16'(j * 7));

    // Randomized windows, some aborted.
    for (int w = 0; w < 30; w++) begin
      k = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : WL;
      for (int j = 0; j < k; j++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
        send(d);
      end
      if (k < WL) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        clear_window();
      end
    end
    repeat (10) @(negedge clk);
    check("pending_results", 32'(exp_q.size()), 0);

`ifdef LBP_TRACKER_ERRCHK_EN
    check("err_none_sticky", 32'(err_sticky), 0);
    check("err_none_cnt", 32'(err_cnt), 0);
    clear_window();
    send(16'd500);
    force_both = 1'b1;
    send(16'd600);
    repeat (2) @(negedge clk);
    force_both = 1'b0;
    check("err1_sticky", 32'(err_sticky), 1);
    check("err1_cnt", 32'(err_cnt), 1);
    force_both = 1'b1;
    send(16'd700);
    repeat (2) @(negedge clk);
    force_both = 1'b0;
    check("err2_cnt", 32'(err_cnt), 2);
    clear_window();
    for (int r = 0; r < 260; r++) begin
      send(16'd1);
      force_both = 1'b1;
      send(16'd2);
      repeat (2) @(negedge clk);
      force_both = 1'b0;
      clear_window();
    end
    @(negedge clk);
    check("err_sat_cnt", 32'(err_cnt), 255);
    check("err_sat_sticky", 32'(err_sticky), 1);
`endif

    repeat (5) @(negedge clk);
    check("w1len_on_never", 32'(on1_seen), 0);
    check("final_pending", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
